// File: rtl/interl_pingpong.sv
// Ping-pong block interleaver: bits are written row-wise into one bank of a
// 1-bit RAM while the other bank is read out column-wise. Each bank holds one
// ROWS x COLS block and carries a full flag that hands it between the writer
// and the reader. The read side is a two-stage elastic pipeline (RAM read
// register, then output register) sharing one advance enable, so the output
// holds steady under backpressure.
module interl_pingpong #(
    parameter int ROW_BITS = 6,
    parameter int COL_BITS = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic out_bit,
    output logic out_sof,
    output logic out_eof
);

    localparam int AW    = ROW_BITS + COL_BITS + 1;
    localparam int DEPTH = 1 << AW;

    localparam logic [ROW_BITS-1:0] ROW_MAX = '1;
    localparam logic [COL_BITS-1:0] COL_MAX = '1;

    // Block storage, address = {bank, row, col}
    logic mem [0:DEPTH-1];
    logic ram_rd_q;

    // Write-side state
    logic                wr_bank_q, wr_bank_d;
    logic [ROW_BITS-1:0] wr_row_q,  wr_row_d;
    logic [COL_BITS-1:0] wr_col_q,  wr_col_d;

    // Read-side state
    logic                rd_bank_q, rd_bank_d;
    logic [ROW_BITS-1:0] rd_row_q,  rd_row_d;
    logic [COL_BITS-1:0] rd_col_q,  rd_col_d;

    logic [1:0] full_q, full_d;

    // Stage 1: qualifiers travelling alongside the RAM read register
    logic s1_valid_q, s1_valid_d;
    logic s1_sof_q,   s1_sof_d;
    logic s1_eof_q,   s1_eof_d;

    // Stage 2: output registers
    logic out_valid_q, out_valid_d;
    logic out_bit_q,   out_bit_d;
    logic out_sof_q,   out_sof_d;
    logic out_eof_q,   out_eof_d;

    logic          wr_fire, wr_last;
    logic          rd_fire, rd_first, rd_last;
    logic          adv;
    logic [AW-1:0] wr_addr, rd_addr;

    assign in_ready  = ~full_q[wr_bank_q];
    assign wr_fire   = in_valid & in_ready;
    assign wr_last   = (wr_row_q == ROW_MAX) && (wr_col_q == COL_MAX);

    // Whole read pipeline advances together when the output slot is free or drained
    assign adv       = ~out_valid_q | out_ready;
    assign rd_fire   = full_q[rd_bank_q] & adv;
    assign rd_first  = (rd_row_q == '0) && (rd_col_q == '0);
    assign rd_last   = (rd_row_q == ROW_MAX) && (rd_col_q == COL_MAX);

    assign wr_addr   = {wr_bank_q, wr_row_q, wr_col_q};
    assign rd_addr   = {rd_bank_q, rd_row_q, rd_col_q};

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;

    // Write pointer: column fastest, wrap into next row, then flip bank
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        if (wr_fire) begin
            if (wr_col_q == COL_MAX) begin
                wr_col_d = '0;
                if (wr_row_q == ROW_MAX) begin
                    wr_row_d  = '0;
                    wr_bank_d = ~wr_bank_q;
                end else begin
                    wr_row_d = wr_row_q + 1'b1;
                end
            end else begin
                wr_col_d = wr_col_q + 1'b1;
            end
        end
    end

    // Read pointer: row fastest, wrap into next column, then flip bank
    always_comb begin
        rd_bank_d = rd_bank_q;
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        if (rd_fire) begin
            if (rd_row_q == ROW_MAX) begin
                rd_row_d = '0;
                if (rd_col_q == COL_MAX) begin
                    rd_col_d  = '0;
                    rd_bank_d = ~rd_bank_q;
                end else begin
                    rd_col_d = rd_col_q + 1'b1;
                end
            end else begin
                rd_row_d = rd_row_q + 1'b1;
            end
        end
    end

    // Full flags: writer sets on its last bit, reader clears on its last read;
    // the two always target different banks so they never collide
    always_comb begin
        full_d = full_q;
        if (wr_fire && wr_last) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (rd_fire && rd_last) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    // Read pipeline: load stage 1 from the issue decision and stage 2 from stage 1
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sof_d    = s1_sof_q;
        s1_eof_d    = s1_eof_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        if (adv) begin
            s1_valid_d  = rd_fire;
            s1_sof_d    = rd_fire & rd_first;
            s1_eof_d    = rd_fire & rd_last;
            out_valid_d = s1_valid_q;
            out_bit_d   = s1_valid_q & ram_rd_q;
            out_sof_d   = s1_sof_q;
            out_eof_d   = s1_eof_q;
        end
    end

    // Block RAM: synchronous write, registered read (banks never alias)
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= in_bit;
        end
        if (rd_fire) begin
            ram_rd_q <= mem[rd_addr];
        end
    end

    // Control and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            full_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eof_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_row_q    <= wr_row_d;
            wr_col_q    <= wr_col_d;
            rd_bank_q   <= rd_bank_d;
            rd_row_q    <= rd_row_d;
            rd_col_q    <= rd_col_d;
            full_q      <= full_d;
            s1_valid_q  <= s1_valid_d;
            s1_sof_q    <= s1_sof_d;
            s1_eof_q    <= s1_eof_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
        end
    end

endmodule

// File: tb/tb_interl_pingpong.sv
// Directed bench for interl_pingpong at 4x8: single blocks with latency,
// continuous streaming, full backpressure, random handshakes and mid-block
// reset, all checked against a block-transpose scoreboard.
module tb_interl_pingpong;

    localparam int RB   = 2;
    localparam int CB   = 3;
    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int BLK  = 32;

    logic clk, rst_n;
    logic in_valid, in_ready, in_bit;
    logic out_valid, out_ready, out_bit, out_sof, out_eof;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int in_cnt  = 0;
    int out_cnt = 0;
    int blk_cnt = 0;
    int rmode   = 0;
    int in_stall, out_gap;
    logic track = 1'b0;
    logic seen_out;

    logic       acc[$];
    logic [2:0] exp_q[$];
    logic       prev_hold, prev_bit, prev_sof, prev_eof;

    interl_pingpong #(
        .ROW_BITS (RB),
        .COL_BITS (CB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_sof   (out_sof),
        .out_eof   (out_eof)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Downstream ready driver: 0 = hold low, 1 = hold high, 2 = random
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 2) out_ready = 1'($urandom_range(1));
            else            out_ready = (rmode == 1);
        end
    end

    // Monitor: scoreboard, output stability and streaming-gap tracking
    initial begin
        logic [2:0] e;
        prev_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc.delete();
                exp_q.delete();
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_bit", out_bit, prev_bit);
                    check("hold_sof", out_sof, prev_sof);
                    check("hold_eof", out_eof, prev_eof);
                end
                prev_hold = out_valid && !out_ready;
                prev_bit  = out_bit;
                prev_sof  = out_sof;
                prev_eof  = out_eof;
                if (track) begin
                    if (!in_ready) in_stall++;
                    if (out_valid) seen_out = 1'b1;
                    else if (seen_out && out_cnt < 4 * BLK) out_gap++;
                end
                if (in_valid && in_ready) begin
                    acc.push_back(in_bit);
                    in_cnt++;
                    if (acc.size() == BLK) begin
                        for (int k = 0; k < BLK; k++)
                            exp_q.push_back({k == BLK - 1, k == 0, acc[(k % ROWS) * COLS + k / ROWS]});
                        acc.delete();
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_bit", out_bit, e[0]);
                        check("out_sof", out_sof, e[1]);
                        check("out_eof", out_eof, e[2]);
                        if (e[2]) begin
                            blk_cnt++;
                            $display("block %0d out complete at cycle %0d", blk_cnt, cyc);
                        end
                    end
                    out_cnt++;
                end
            end
        end
    end

    // Offer one bit (with p% chance per cycle) and wait for it to be accepted
    task automatic send_bit(input logic b, input int p);
        int   guard;
        logic rdy;
        while ($urandom_range(99) >= p) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_bit   = b;
        guard    = 0;
        do begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 2000);
        if (!rdy) check("in_timeout", 0, 1);
    endtask

    task automatic wait_out(input int n);
        int g = 0;
        while (out_cnt < n && g < 5000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (out_cnt < n) check("drain_timeout", out_cnt, n);
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        int   n, t0;
        logic b;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bit", out_bit, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eof", out_eof, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);

        // Single blocks: parity pattern and its inverse, with latency check
        rmode = 1;
        @(posedge clk);
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            out_cnt = 0;
            for (int i = 0; i < BLK - 1; i++) send_bit(((i & 1) ^ pass) != 0, 100);
            in_bit   = (((BLK - 1) & 1) ^ pass) != 0;
            in_valid = 1'b1;
            check("lat_rdy", in_ready, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!out_valid && n < 10);
            check("lat_edges", n, 2);
            check("lat_bit", out_bit, pass);
            check("lat_sof", out_sof, 1);
            wait_out(BLK);
            check("single_count", out_cnt, BLK);
        end

        // Continuous 4 blocks: no input stall, no output gap
        out_cnt  = 0;
        in_stall = 0;
        out_gap  = 0;
        seen_out = 1'b0;
        track    = 1'b1;
        t0       = cyc;
        for (int i = 0; i < 4 * BLK; i++) send_bit(1'($urandom_range(1)), 100);
        in_valid = 1'b0;
        check("cont_cycles", cyc - t0, 4 * BLK);
        wait_out(4 * BLK);
        track = 1'b0;
        check("cont_in_stall", in_stall, 0);
        check("cont_out_gap", out_gap, 0);
        check("cont_count", out_cnt, 4 * BLK);

        // Full backpressure: both banks fill, then release
        rmode = 0;
        @(posedge clk);
        #1;
        in_cnt  = 0;
        out_cnt = 0;
        for (int i = 0; i < 2 * BLK; i++) begin
            if (i == 2 * BLK - 1) check("bp_rdy_last", in_ready, 1);
            send_bit(1'($urandom_range(1)), 100);
        end
        b        = 1'($urandom_range(1));
        in_bit   = b;
        in_valid = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("bp_stalled", in_ready, 0);
        check("bp_in_cnt", in_cnt, 2 * BLK);
        check("bp_no_out", out_cnt, 0);
        rmode = 1;
        send_bit(b, 100);
        for (int i = 2 * BLK + 1; i < 3 * BLK; i++) send_bit(1'($urandom_range(1)), 100);
        in_valid = 1'b0;
        wait_out(3 * BLK);
        check("bp_count", out_cnt, 3 * BLK);

        // Random handshakes on both sides over 10 blocks
        rmode   = 2;
        out_cnt = 0;
        for (int i = 0; i < 10 * BLK; i++) send_bit(1'($urandom_range(1)), 50);
        in_valid = 1'b0;
        wait_out(10 * BLK);
        check("rand_count", out_cnt, 10 * BLK);

        // Reset while block 0 drains and block 1 is partly written
        rmode = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < BLK + 20; i++) send_bit(1'($urandom_range(1)), 100);
        in_valid = 1'b0;
        check("rstm_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #2;
        check("rstm_valid", out_valid, 0);
        check("rstm_rdy", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rstm_idle_valid", out_valid, 0);
        check("rstm_idle_rdy", in_ready, 1);
        out_cnt = 0;
        for (int i = 0; i < BLK; i++) send_bit(1'($urandom_range(1)), 100);
        in_valid = 1'b0;
        wait_out(BLK);
        check("rstm_count", out_cnt, BLK);

        check("sb_empty", exp_q.size(), 0);
        check("acc_empty", acc.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
